// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared twiddle index type, CSD constants and W8^k source decode
package fft_pkg;

    typedef logic [2:0] twiddle_idx_t;

    localparam int CSD_COEF  = 181;
    localparam int CSD_SHIFT = 8;
    localparam int CSD_ROUND = 1 << (CSD_SHIFT - 1);

    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_B    = 2'd1,
        SRC_SUM  = 2'd2,
        SRC_DIFF = 2'd3
    } src_sel_t;

    typedef struct packed {
        src_sel_t sel;
        logic     neg;
    } comp_sel_t;

    typedef struct packed {
        comp_sel_t re;
        comp_sel_t im;
    } twiddle_sel_t;

    function automatic comp_sel_t comp_sel(input src_sel_t sel, input logic neg);
        comp_sel_t c;
        c.sel = sel;
        c.neg = neg;
        return c;
    endfunction

    // SUM = a+b, DIFF = b-a; negation happens before the 0.707 scaling, so
    // odd k use c(-s) rather than -c(s).
    function automatic twiddle_sel_t twiddle_decode(input twiddle_idx_t k);
        twiddle_sel_t t;
        t.re = comp_sel(SRC_A, 1'b0);
        t.im = comp_sel(SRC_B, 1'b0);
        case (k)
            3'd1: begin t.re = comp_sel(SRC_SUM,  1'b0); t.im = comp_sel(SRC_DIFF, 1'b0); end
            3'd2: begin t.re = comp_sel(SRC_B,    1'b0); t.im = comp_sel(SRC_A,    1'b1); end
            3'd3: begin t.re = comp_sel(SRC_DIFF, 1'b0); t.im = comp_sel(SRC_SUM,  1'b1); end
            3'd4: begin t.re = comp_sel(SRC_A,    1'b1); t.im = comp_sel(SRC_B,    1'b1); end
            3'd5: begin t.re = comp_sel(SRC_SUM,  1'b1); t.im = comp_sel(SRC_DIFF, 1'b1); end
            3'd6: begin t.re = comp_sel(SRC_B,    1'b1); t.im = comp_sel(SRC_A,    1'b0); end
            3'd7: begin t.re = comp_sel(SRC_DIFF, 1'b1); t.im = comp_sel(SRC_SUM,  1'b0); end
            default: ;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/csd_scale_0707.sv
// rtl/csd_scale_0707.sv - x*181/256 shift-add scaler with round and saturate over stages S2/S3
module csd_scale_0707
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld2,
    input  logic                     ld3,
    input  logic signed [DATA_W+1:0] x,
    input  logic                     scale,
    output logic signed [DATA_W-1:0] y,
    output logic                     ovf
);

    localparam int XW = DATA_W + 2;
    localparam int PW = XW + CSD_SHIFT;
    localparam logic signed [PW-1:0] RND = (ROUND != 0) ? PW'(CSD_ROUND) : '0;

    logic signed [PW-1:0]     x_w;
    logic signed [PW-1:0]     p_hi;
    logic signed [PW-1:0]     p_lo;
    logic signed [PW-1:0]     prod;
    logic signed [XW-1:0]     x2;
    logic                     scale2;
    logic signed [XW-1:0]     val;
    logic signed [DATA_W-1:0] y_nxt;
    logic                     ovf_nxt;
    logic                     unused_frac;

    assign x_w = {{CSD_SHIFT{x[XW-1]}}, x};

    // 181 = 128 + 32 + 16 + 4 + 1, split into two partial sums at S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_hi   <= '0;
            p_lo   <= '0;
            x2     <= '0;
            scale2 <= 1'b0;
        end else if (ld2) begin
            p_hi   <= (x_w <<< 7) + (x_w <<< 5);
            p_lo   <= (x_w <<< 4) + (x_w <<< 2) + x_w;
            x2     <= x;
            scale2 <= scale;
        end
    end

    always_comb begin
        prod    = p_hi + p_lo + RND;
        val     = scale2 ? prod[PW-1:CSD_SHIFT] : x2;
        ovf_nxt = !((&val[XW-1:DATA_W-1]) || !(|val[XW-1:DATA_W-1]));
        if (!ovf_nxt || SAT == 0)
            y_nxt = val[DATA_W-1:0];
        else
            y_nxt = val[XW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    assign unused_frac = ^prod[CSD_SHIFT-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (ld3) begin
            y   <= y_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: rtl/twiddle_mult_w8.sv
// rtl/twiddle_mult_w8.sv - complex sample times W8^k in a three-stage elastic pipeline
module twiddle_mult_w8
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  twiddle_idx_t             in_k,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_ovf
);

    localparam int XW = DATA_W + 2;

    logic                 v1, v2, v3;
    logic                 ld1, ld2, ld3;
    logic signed [XW-1:0] a_x, b_x, sum_x, diff_x;
    logic signed [XW-1:0] re_sel, im_sel;
    logic signed [XW-1:0] s1_re, s1_im;
    logic                 s1_re_scl, s1_im_scl;
    logic                 ovf_re, ovf_im;
    twiddle_sel_t         tsel;

    function automatic logic signed [XW-1:0] pick(
        input comp_sel_t            cs,
        input logic signed [XW-1:0] a,
        input logic signed [XW-1:0] b,
        input logic signed [XW-1:0] s,
        input logic signed [XW-1:0] d
    );
        logic signed [XW-1:0] v;
        case (cs.sel)
            SRC_A:   v = a;
            SRC_B:   v = b;
            SRC_SUM: v = s;
            default: v = d;
        endcase
        return cs.neg ? -v : v;
    endfunction

    // Each stage advances when it is empty or its successor moves this cycle
    assign ld3       = v2 && (!v3 || out_ready);
    assign ld2       = v1 && (!v2 || ld3);
    assign in_ready  = !v1 || ld2;
    assign ld1       = in_valid && in_ready;
    assign out_valid = v3;
    assign out_ovf   = ovf_re || ovf_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1)            v1 <= 1'b1;
            else if (ld2)       v1 <= 1'b0;
            if (ld2)            v2 <= 1'b1;
            else if (ld3)       v2 <= 1'b0;
            if (ld3)            v3 <= 1'b1;
            else if (out_ready) v3 <= 1'b0;
        end
    end

    // Two guard bits cover both a+b and the negation of a full-scale sum
    always_comb begin
        a_x    = {{2{in_re[DATA_W-1]}}, in_re};
        b_x    = {{2{in_im[DATA_W-1]}}, in_im};
        sum_x  = a_x + b_x;
        diff_x = b_x - a_x;
        tsel   = twiddle_decode(in_k);
        re_sel = pick(tsel.re, a_x, b_x, sum_x, diff_x);
        im_sel = pick(tsel.im, a_x, b_x, sum_x, diff_x);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_re     <= '0;
            s1_im     <= '0;
            s1_re_scl <= 1'b0;
            s1_im_scl <= 1'b0;
        end else if (ld1) begin
            s1_re     <= re_sel;
            s1_im     <= im_sel;
            s1_re_scl <= (tsel.re.sel == SRC_SUM) || (tsel.re.sel == SRC_DIFF);
            s1_im_scl <= (tsel.im.sel == SRC_SUM) || (tsel.im.sel == SRC_DIFF);
        end
    end

    csd_scale_0707 #(
        .DATA_W (DATA_W),
        .ROUND  (ROUND),
        .SAT    (SAT)
    ) u_scale_re (
        .clk   (clk),
        .rst   (rst),
        .ld2   (ld2),
        .ld3   (ld3),
        .x     (s1_re),
        .scale (s1_re_scl),
        .y     (out_re),
        .ovf   (ovf_re)
    );

    csd_scale_0707 #(
        .DATA_W (DATA_W),
        .ROUND  (ROUND),
        .SAT    (SAT)
    ) u_scale_im (
        .clk   (clk),
        .rst   (rst),
        .ld2   (ld2),
        .ld3   (ld3),
        .x     (s1_im),
        .scale (s1_im_scl),
        .y     (out_im),
        .ovf   (ovf_im)
    );

endmodule
